baby_store_loader: RTL and testbench
====================================

Name: baby_store_loader

Overview:
- Sits between a program image module (32 words, already in machine bit order) and the Baby main store.
- On a load request, copies the image into the store one word per accepted write.
- Optionally reads every word back and compares it against the image.
- Holds the CPU halted for the whole operation and reports completion and the first mismatch address.

Parameters:
- WORDS, 32, number of store lines loaded (address range 0..WORDS-1).
- ADDR_W, 5, store address width; WORDS must equal 2**ADDR_W.
- VERIFY, 1, 1 = read-back/compare pass after writing; 0 = skip it.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- load_req  in  1  start request; sampled only in IDLE.
- prog_image  in  [0:WORDS-1][31:0]  program image; must stay static while busy.
- store_addr  out  ADDR_W  store line address.
- store_wdata  out  32  write data (prog_image[store_addr]).
- store_we  out  1  write request.
- store_re  out  1  read request.
- store_ready  in  1  store accepts the current request when high.
- store_rdata  in  32  read data, valid exactly 1 cycle after an accepted read.
- cpu_halt  out  1  high while busy (WRITE/READ/DRAIN).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- verify_err  out  1  sticky mismatch flag.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE, address counter 0, compare pipe empty. Reset mid-operation aborts immediately; no further store requests are issued.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, load_req=1: go to WRITE with addr=0; clear verify_err and err_addr.
- WRITE: store_we=1, store_addr=addr, store_wdata=prog_image[addr].
  - A write is accepted on a rising edge where store_we & store_ready.
  - Accepted, addr<WORDS-1: addr+1.
  - Accepted, addr=WORDS-1: addr wraps to 0, go to READ if VERIFY, else DONE.
- READ: store_re=1, store_addr=addr.
  - Reads issue back-to-back, one per accepted edge.
  - Each acceptance loads a compare stage (valid, address, expected word).
  - Acceptance at addr=WORDS-1 goes to DRAIN.
- Compare stage: in the cycle after acceptance, store_rdata is compared with the expected word. On mismatch with verify_err=0: set verify_err and capture err_addr. Later mismatches do not overwrite err_addr.
- DRAIN: one cycle to compare the last word, then DONE.
- DONE: done=1 for one cycle, then IDLE. verify_err and err_addr hold until the next load start.
- store_ready low stalls WRITE/READ. store_addr, store_wdata, store_we and store_re must hold stable during a stall.
- store_we and store_re are never high together, and both are low in IDLE, DRAIN and DONE.
- load_req while busy is ignored and is not queued. load_req held high in DONE or IDLE starts a new load from IDLE on the next edge.
- Latency with store_ready constantly 1 (edge 0 = load_req sampled):
  - Writes accepted at edges 1..32.
  - VERIFY=1: reads accepted at edges 33..64, last compare at edge 65, done high in the cycle after edge 65.
  - VERIFY=0: done high in the cycle after edge 32.

Decomposition:
- Shared package baby_pkg:
  - WORD_W=32 and STORE_WORDS=32.
  - word_t and addr_t typedefs.
  - loader_state_t enum (IDLE, WRITE, READ, DRAIN, DONE).
- Sub-module loader_cmp_stage: the 1-deep registered compare pipe (valid, addr, expected word, sticky error/first-address capture). Everything else is a single FSM plus address counter.

Test Plan:
- Load PARABOLA image, store_ready=1, VERIFY=1: store lines 0..31 equal the image; done pulses after edge 65; verify_err=0; cpu_halt high edges 1..65.
- Same load with a store model that corrupts line 17 on read (bit 0 flipped): verify_err=1, err_addr=17.
- Corrupt lines 5 and 20: err_addr=5 (first-only capture).
- store_ready toggling 1,0,0,1… during WRITE and READ: request outputs stay stable across stall cycles; every line written exactly once; done pulses after 64 accepted requests plus 1 drain cycle.
- load_req pulsed at write address 10: ignored; exactly 32 writes; one done pulse.
- rst asserted at write address 12: next cycle all outputs 0 and state IDLE; a fresh load_req rewrites lines from 0.
- VERIFY=0: 32 writes, no store_re, done in the cycle after edge 32.

Source files
------------

// File: rtl/baby_pkg.sv
// Shared types for the Baby main-store loader: word/address types and loader FSM states.
package baby_pkg;
    localparam int WORD_W       = 32;
    localparam int STORE_WORDS  = 32;
    localparam int STORE_ADDR_W = $clog2(STORE_WORDS);

    typedef logic [WORD_W-1:0]       word_t;
    typedef logic [STORE_ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } loader_state_t;
endpackage

// File: rtl/loader_cmp_stage.sv
// One-deep read-back compare pipe: holds the expected word for the read in flight and
// records the address of the first mismatch in a sticky error flag.
module loader_cmp_stage
    import baby_pkg::*;
#(
    parameter int ADDR_W = STORE_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  word_t             exp_i,
    input  word_t             rdata_i,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o
);
    logic              vld_q;
    logic [ADDR_W-1:0] addr_q;
    word_t             exp_q;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // rdata_i is only meaningful in the cycle directly after an accepted read.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (clr_i) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end else if (vld_q && (rdata_i != exp_q) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q      <= 1'b0;
            addr_q     <= '0;
            exp_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            vld_q      <= load_i;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            if (load_i) begin
                addr_q <= addr_i;
                exp_q  <= exp_i;
            end
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
endmodule

// File: rtl/baby_store_loader.sv
// Copies a static program image into the Baby main store, optionally reads it back to
// verify, and keeps the CPU halted until the operation completes.
module baby_store_loader
    import baby_pkg::*;
#(
    parameter int WORDS  = STORE_WORDS,
    parameter int ADDR_W = STORE_ADDR_W,
    parameter int VERIFY = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_req_i,
    input  logic [0:WORDS-1][31:0]    prog_image_i,
    output logic [ADDR_W-1:0]         store_addr_o,
    output logic [31:0]               store_wdata_o,
    output logic                      store_we_o,
    output logic                      store_re_o,
    input  logic                      store_ready_i,
    input  logic [31:0]               store_rdata_i,
    output logic                      cpu_halt_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      verify_err_o,
    output logic [ADDR_W-1:0]         err_addr_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start, rd_acc;
    word_t             img_word;

    assign img_word = prog_image_i[addr_q];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        start         = 1'b0;
        rd_acc        = 1'b0;
        store_we_o    = 1'b0;
        store_re_o    = 1'b0;
        store_addr_o  = '0;
        store_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (load_req_i) begin
                    start   = 1'b1;
                    addr_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                store_we_o    = 1'b1;
                store_addr_o  = addr_q;
                store_wdata_o = img_word;
                if (store_ready_i) begin
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        state_d = (VERIFY != 0) ? READ : DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            READ: begin
                store_re_o   = 1'b1;
                store_addr_o = addr_q;
                if (store_ready_i) begin
                    rd_acc = 1'b1;
                    if (addr_q == LAST) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign cpu_halt_o = (state_q == WRITE) || (state_q == READ) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);

    loader_cmp_stage #(.ADDR_W(ADDR_W)) u_cmp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (start),
        .load_i     (rd_acc),
        .addr_i     (addr_q),
        .exp_i      (img_word),
        .rdata_i    (store_rdata_i),
        .err_o      (verify_err_o),
        .err_addr_o (err_addr_o)
    );
endmodule

// File: tb/tb_baby_store_loader.sv
// Scoreboard bench for baby_store_loader: stimulus pushes expected load results, a
// negedge monitor tracks store traffic and checks each result when done pulses.
module tb_baby_store_loader;
    typedef struct {
        logic       err;
        logic [4:0] eaddr;
        int         lat;
        int         nreads;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic [0:31][31:0] img;
    logic [4:0]        store_addr;
    logic [31:0]       store_wdata, store_rdata;
    logic              store_we, store_re, store_ready;
    logic              cpu_halt, busy, done, verify_err;
    logic [4:0]        err_addr;

    logic              load_req2 = 1'b0;
    logic [4:0]        store_addr2, err_addr2;
    logic [31:0]       store_wdata2;
    logic              store_we2, store_re2, cpu_halt2, busy2, done2, verify_err2;

    logic [31:0] mem [32];
    logic [31:0] corrupt = '0;
    int          edge_cnt = 0;
    int          n_cmp = 0, n_fail = 0;
    int          mode = 0;
    exp_t        q[$];

    int          start_edge = 0;
    logic        active = 1'b0;
    int          halt_cnt, rcnt;
    int          wcnt [32];
    logic [38:0] prev;
    logic        prev_stall = 1'b0;
    logic [3:0]  pat = 4'b1001;

    baby_store_loader #(.WORDS(32), .ADDR_W(5), .VERIFY(1)) dut (
        .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .prog_image_i(img),
        .store_addr_o(store_addr), .store_wdata_o(store_wdata), .store_we_o(store_we),
        .store_re_o(store_re), .store_ready_i(store_ready), .store_rdata_i(store_rdata),
        .cpu_halt_o(cpu_halt), .busy_o(busy), .done_o(done), .verify_err_o(verify_err),
        .err_addr_o(err_addr)
    );

    baby_store_loader #(.WORDS(32), .ADDR_W(5), .VERIFY(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .load_req_i(load_req2), .prog_image_i(img),
        .store_addr_o(store_addr2), .store_wdata_o(store_wdata2), .store_we_o(store_we2),
        .store_re_o(store_re2), .store_ready_i(1'b1), .store_rdata_i(32'h0),
        .cpu_halt_o(cpu_halt2), .busy_o(busy2), .done_o(done2), .verify_err_o(verify_err2),
        .err_addr_o(err_addr2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Store model: read data appears one cycle after an accepted read, optionally corrupted.
    always @(posedge clk) begin
        if (store_we && store_ready) mem[store_addr] <= store_wdata;
        if (store_re && store_ready) store_rdata <= mem[store_addr] ^ {31'b0, corrupt[store_addr]};
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, req, edge_cnt);
        end
    endtask

    initial begin
        store_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 1 && active) store_ready = pat[(edge_cnt - start_edge) % 4];
            else store_ready = 1'b1;
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                active     = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {store_addr, store_wdata, store_we, store_re}, prev);
                prev       = {store_addr, store_wdata, store_we, store_re};
                prev_stall = (store_we || store_re) && !store_ready;
                if (!busy && load_req) begin
                    active     = 1'b1;
                    start_edge = edge_cnt + 1;
                    halt_cnt   = 0;
                    rcnt       = 0;
                    for (int i = 0; i < 32; i++) wcnt[i] = 0;
                end else if (active) begin
                    if (edge_cnt == start_edge) chk("err_clr_on_start", verify_err, 0);
                    chk("we_re_excl", store_we & store_re, 0);
                    if (cpu_halt) halt_cnt++;
                    if (store_we && store_ready) wcnt[store_addr]++;
                    if (store_re && store_ready) rcnt++;
                    if (done) begin
                        active = 1'b0;
                        if (q.size() == 0) begin
                            chk("sb_expected_done", 0, 1);
                        end else begin
                            exp_t e;
                            int bw, bm;
                            e  = q.pop_front();
                            bw = 0;
                            bm = 0;
                            chk("done_latency", edge_cnt - start_edge, e.lat);
                            chk("halt_cycles", halt_cnt, e.lat);
                            chk("verify_err", verify_err, e.err);
                            chk("err_addr", err_addr, e.eaddr);
                            chk("read_count", rcnt, e.nreads);
                            for (int i = 0; i < 32; i++) begin
                                if (wcnt[i] != 1) bw++;
                                if (mem[i] != img[i]) bm++;
                            end
                            chk("write_once_lines_bad", bw, 0);
                            chk("mem_image_lines_bad", bm, 0);
                        end
                    end
                end else begin
                    chk("spurious_done", done, 0);
                end
            end
        end
    end

    task automatic start_load();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 600);
        chk("done_timeout", busy, 0);
    endtask

    task automatic wait_write_addr(input logic [4:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(store_we && store_addr == a) && n < 200);
        chk("reach_write_addr", store_addr, a);
    endtask

    function automatic exp_t mk(input logic err, input logic [4:0] ea, input int lat, input int nr);
        exp_t e;
        e.err = err; e.eaddr = ea; e.lat = lat; e.nreads = nr;
        return e;
    endfunction

    initial begin
        int w2, r2, bad2, lat2;
        for (int i = 0; i < 32; i++) begin
            img[i] = 32'hA500_0000 ^ (i * 32'h0001_0203) ^ {i[7:0], 24'h0};
            mem[i] = 32'hDEAD_BEEF;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {store_addr, store_wdata, store_we, store_re, cpu_halt, busy,
                              done, verify_err, err_addr}, 0);

        // Clean load with verify.
        q.push_back(mk(1'b0, 5'd0, 65, 32));
        start_load();
        wait_done();

        // Line 17 corrupted on read; error must persist into IDLE.
        corrupt = 32'h0002_0000;
        q.push_back(mk(1'b1, 5'd17, 65, 32));
        start_load();
        wait_done();
        repeat (3) @(negedge clk);
        chk("err_sticky_idle", {verify_err, err_addr}, {1'b1, 5'd17});

        // Lines 5 and 20 corrupted: first one wins.
        corrupt = 32'h0010_0020;
        q.push_back(mk(1'b1, 5'd5, 65, 32));
        start_load();
        wait_done();

        // store_ready pattern 1,0,0,1: 64 accepts finish at edge 128, drain at 129.
        corrupt = '0;
        mode    = 1;
        q.push_back(mk(1'b0, 5'd0, 129, 32));
        start_load();
        wait_done();
        mode = 0;

        // load_req while busy must be ignored.
        q.push_back(mk(1'b0, 5'd0, 65, 32));
        start_load();
        wait_write_addr(5'd10);
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
        wait_done();

        // Reset mid-write, then a fresh load.
        for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD_BEEF;
        start_load();
        wait_write_addr(5'd12);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", {store_addr, store_wdata, store_we, store_re, cpu_halt, busy,
                              done, verify_err, err_addr}, 0);
        @(posedge clk); #1 rst = 1'b0;
        q.push_back(mk(1'b0, 5'd0, 65, 32));
        start_load();
        wait_done();

        // VERIFY=0 instance: 32 writes, no reads, done after edge 32.
        w2 = 0; r2 = 0; bad2 = 0; lat2 = -1;
        @(posedge clk); #1 load_req2 = 1'b1;
        @(posedge clk); #1 load_req2 = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (store_we2) begin
                w2++;
                if (store_wdata2 != img[store_addr2]) bad2++;
            end
            if (store_re2) r2++;
            if (done2) begin
                lat2 = k;
                break;
            end
        end
        chk("nv_done_latency", lat2, 32);
        chk("nv_writes", w2, 32);
        chk("nv_reads", r2, 0);
        chk("nv_wdata_bad", bad2, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
